// File: rtl/biriscv_fetch_frontend.sv
// Fetch front-end: 64-bit aligned I-cache requests, one outstanding, registered bundle to decode.
// Define BIRISCV_FETCH_SKID_EN to add a 1-entry skid buffer behind the output register.
module biriscv_fetch_frontend #(
    parameter logic [31:0] BOOT_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic [1:0]  branch_priv_i,
    input  logic [1:0]  bp_taken_i,
    input  logic [31:0] bp_next_pc_i,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,
    output logic        fetch_valid_o,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [1:0]  fetch_pred_branch_o,
    output logic        fetch_fault_fetch_o,
    output logic        fetch_fault_page_o,
    input  logic        fetch_accept_i
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic        faultPage;
        logic        faultFetch;
        logic [1:0]  pred;
        logic [31:0] pc;
        logic [63:0] instr;
    } bundle_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [1:0]  r_priv;
    logic        r_outstanding;
    logic        r_drop;
    logic        r_nopPend;
    logic        r_reqNop;
    logic [31:0] r_reqPc;
    logic [1:0]  r_reqPred;
    logic        r_valid;
    bundle_t     r_out;

    logic        w_canAbsorb;
    logic        w_reqFire;
    logic        w_respFire;
    logic        w_capture;
    logic        w_outAccept;
    logic        w_respFault;
    logic [63:0] w_respInst;
    bundle_t     w_resp;

`ifdef BIRISCV_FETCH_SKID_EN
    logic        r_skidValid;
    bundle_t     r_skid;

    assign w_canAbsorb = !r_skidValid;
`else
    // Without a skid the response must always find the output register free.
    assign w_canAbsorb = !r_valid || fetch_accept_i;
`endif

    assign w_outAccept = r_valid && fetch_accept_i;
    assign icache_rd_o = (r_state == ST_RUN) && !r_outstanding && w_canAbsorb && !branch_request_i;
    assign icache_pc_o = {r_pc[31:3], 3'b000};
    assign icache_priv_o = r_priv;

    assign w_reqFire = icache_rd_o && icache_accept_i;
    assign w_respFire = icache_valid_i && r_outstanding;
    assign w_capture = w_respFire && !r_drop && !branch_request_i;
    assign w_respFault = icache_error_i || icache_page_fault_i;
    assign w_respInst = r_reqNop ? {icache_inst_i[63:32], NOP} : icache_inst_i;
    assign w_resp = {icache_page_fault_i, icache_error_i, r_reqPred, r_reqPc, w_respInst};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_pc          <= BOOT_PC;
            r_priv        <= 2'b11;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
            r_nopPend     <= 1'b0;
            r_reqNop      <= 1'b0;
            r_reqPc       <= '0;
            r_reqPred     <= '0;
        end else begin
            if (w_respFire) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end
            if (w_reqFire) begin
                r_outstanding <= 1'b1;
                r_reqPc       <= r_pc;
                r_reqPred     <= bp_taken_i;
                r_reqNop      <= r_nopPend;
                r_nopPend     <= 1'b0;
                r_pc          <= (|bp_taken_i) ? bp_next_pc_i : {r_pc[31:3] + 29'd1, 3'b000};
            end
            // A response landing in the redirect cycle is itself the stale one, so no drop is armed.
            if (branch_request_i) begin
                r_pc      <= branch_pc_i & 32'hFFFF_FFFC;
                r_priv    <= branch_priv_i;
                r_nopPend <= branch_pc_i[2];
                r_drop    <= r_outstanding && !icache_valid_i;
            end
            case (r_state)
                ST_IDLE: r_state <= ST_RUN;
                ST_RUN:  if (w_capture && w_respFault) r_state <= ST_HALT;
                ST_HALT: if (branch_request_i) r_state <= ST_RUN;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BIRISCV_FETCH_SKID_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_out       <= '0;
            r_skidValid <= 1'b0;
            r_skid      <= '0;
        end else if (branch_request_i) begin
            r_valid     <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_outAccept || !r_valid) begin
            if (r_skidValid) begin
                r_out       <= r_skid;
                r_valid     <= 1'b1;
                r_skidValid <= w_capture;
                if (w_capture) r_skid <= w_resp;
            end else if (w_capture) begin
                r_out   <= w_resp;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_capture) begin
            r_skid      <= w_resp;
            r_skidValid <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (branch_request_i) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_out   <= w_resp;
            r_valid <= 1'b1;
        end else if (w_outAccept) begin
            r_valid <= 1'b0;
        end
    end
`endif

    assign fetch_valid_o       = r_valid;
    assign fetch_instr_o       = r_out.instr;
    assign fetch_pc_o          = r_out.pc;
    assign fetch_pred_branch_o = r_out.pred;
    assign fetch_fault_fetch_o = r_out.faultFetch;
    assign fetch_fault_page_o  = r_out.faultPage;

endmodule

// File: tb/tb_biriscv_fetch_frontend.sv
// Scoreboard bench for biriscv_fetch_frontend: a modelled I-cache feeds responses and
// expected bundles are queued on delivery and compared whenever fetch_valid_o is high.
module tb_biriscv_fetch_frontend;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] instr;
        logic [1:0]  pred;
        logic        page;
        logic        err;
    } expBundle_t;

`ifdef BIRISCV_FETCH_SKID_EN
    localparam int STALL_EXTRA = 1;
`else
    localparam int STALL_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        branch_request_i;
    logic [31:0] branch_pc_i;
    logic [1:0]  branch_priv_i;
    logic [1:0]  bp_taken_i;
    logic [31:0] bp_next_pc_i;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic [63:0] icache_inst_i;
    logic        icache_error_i;
    logic        icache_page_fault_i;
    logic        fetch_valid_o;
    logic [63:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic [1:0]  fetch_pred_branch_o;
    logic        fetch_fault_fetch_o;
    logic        fetch_fault_page_o;
    logic        fetch_accept_i;

    biriscv_fetch_frontend #(.BOOT_PC(32'h8000_0000)) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .branch_request_i    (branch_request_i),
        .branch_pc_i         (branch_pc_i),
        .branch_priv_i       (branch_priv_i),
        .bp_taken_i          (bp_taken_i),
        .bp_next_pc_i        (bp_next_pc_i),
        .icache_rd_o         (icache_rd_o),
        .icache_pc_o         (icache_pc_o),
        .icache_priv_o       (icache_priv_o),
        .icache_accept_i     (icache_accept_i),
        .icache_valid_i      (icache_valid_i),
        .icache_inst_i       (icache_inst_i),
        .icache_error_i      (icache_error_i),
        .icache_page_fault_i (icache_page_fault_i),
        .fetch_valid_o       (fetch_valid_o),
        .fetch_instr_o       (fetch_instr_o),
        .fetch_pc_o          (fetch_pc_o),
        .fetch_pred_branch_o (fetch_pred_branch_o),
        .fetch_fault_fetch_o (fetch_fault_fetch_o),
        .fetch_fault_page_o  (fetch_fault_page_o),
        .fetch_accept_i      (fetch_accept_i)
    );

    always #5 clk = ~clk;

    int compareCount = 0;
    int mismatchCount = 0;
    int cycle = 0;

    expBundle_t expQ[$];

    // Fetcher model state
    logic [31:0] modelPc = 32'h8000_0000;
    logic [1:0]  modelPriv = 2'b11;
    logic        modelNop = 1'b0;
    logic        modelHalt = 1'b0;

    // I-cache model state
    logic        cacheAccept = 1'b1;
    int          cacheLatency = 0;
    logic        respPending = 1'b0;
    int          respWait = 0;
    logic [31:0] respPc = '0;
    logic [1:0]  respPred = '0;
    logic        respNop = 1'b0;
    logic        respPage = 1'b0;
    logic        respErr = 1'b0;
    logic        stale = 1'b0;
    logic        faultArmPage = 1'b0;
    logic        deliveredNow = 1'b0;

    // Predictor stimulus and observation hooks
    logic        bpArmed = 1'b0;
    logic [31:0] bpPc = '0;
    logic [31:0] bpTarget = 32'h8000_0100;
    logic        bpFollow = 1'b0;
    logic [31:0] bpNextReq = '0;
    logic        watchReq = 1'b0;
    logic [31:0] reqAfterBr = '0;
    int          rdSeen = 0;
    int          firstRdCycle = 0;
    int          firstValidCycle = 0;
    int          windowCount = 0;

    function automatic logic [63:0] memBundle(input logic [31:0] addr);
        return {addr ^ 32'h1357_9BDF, addr ^ 32'h2468_ACE0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // One clock cycle: drive inputs, sample after settling, update models, advance to next negedge.
    task automatic applyStimulus(input logic br, input logic [31:0] brPc, input logic [1:0] brPriv, input logic acc);
        logic        delivering;
        logic        wasPending;
        logic        hs;
        logic [31:0] reqAddr;
        expBundle_t  e;

        delivering = respPending && (respWait == 0);
        wasPending = respPending;
        reqAddr = {modelPc[31:3], 3'b000};
        branch_request_i = br;
        branch_pc_i = brPc;
        branch_priv_i = brPriv;
        fetch_accept_i = acc;
        icache_accept_i = cacheAccept;
        if (bpArmed && reqAddr == bpPc) begin
            bp_taken_i = 2'b10;
            bp_next_pc_i = bpTarget;
        end else begin
            bp_taken_i = 2'b00;
            bp_next_pc_i = 32'hDEAD_BEE8;
        end
        icache_valid_i = delivering;
        icache_inst_i = delivering ? memBundle({respPc[31:3], 3'b000}) : 64'h0;
        icache_page_fault_i = delivering && respPage;
        icache_error_i = delivering && respErr;
        #1;
        cycle++;
        hs = icache_rd_o && icache_accept_i;
        deliveredNow = 1'b0;
        if (icache_rd_o) rdSeen++;
        if (icache_rd_o && firstRdCycle == 0) firstRdCycle = cycle;

        if (fetch_valid_o) begin
            if (firstValidCycle == 0) firstValidCycle = cycle;
            checkOutput("bundleExpected", {63'b0, expQ.size() != 0}, 64'd1);
            if (expQ.size() != 0) begin
                e = expQ[0];
                checkOutput("fetchPc", {32'b0, fetch_pc_o}, {32'b0, e.pc});
                checkOutput("fetchInstr", fetch_instr_o, e.instr);
                checkOutput("fetchPred", {62'b0, fetch_pred_branch_o}, {62'b0, e.pred});
                checkOutput("faultPage", {63'b0, fetch_fault_page_o}, {63'b0, e.page});
                checkOutput("faultFetch", {63'b0, fetch_fault_fetch_o}, {63'b0, e.err});
                if (acc && !br) begin
                    void'(expQ.pop_front());
                    if (firstValidCycle != 0 && cycle < firstValidCycle + 20) windowCount++;
                end
            end
        end

        if (delivering) begin
            respPending = 1'b0;
            if (stale) begin
                stale = 1'b0;
            end else if (!br) begin
                e.pc = respPc;
                e.instr = memBundle({respPc[31:3], 3'b000});
                if (respNop) e.instr[31:0] = 32'h0000_0013;
                e.pred = respPred;
                e.page = respPage;
                e.err = respErr;
                expQ.push_back(e);
                deliveredNow = 1'b1;
                if (respPage || respErr) modelHalt = 1'b1;
            end
        end else if (respPending) begin
            respWait--;
        end

        if (hs) begin
            checkOutput("reqNoOverlap", {63'b0, wasPending}, 64'd0);
            checkOutput("reqPc", {32'b0, icache_pc_o}, {32'b0, reqAddr});
            checkOutput("reqPriv", {62'b0, icache_priv_o}, {62'b0, modelPriv});
            if (watchReq) begin
                reqAfterBr = icache_pc_o;
                watchReq = 1'b0;
            end
            if (bpFollow) begin
                bpNextReq = icache_pc_o;
                bpFollow = 1'b0;
            end
            respPending = 1'b1;
            respWait = cacheLatency;
            respPc = modelPc;
            respPred = bp_taken_i;
            respNop = modelNop;
            respPage = faultArmPage;
            respErr = 1'b0;
            faultArmPage = 1'b0;
            modelNop = 1'b0;
            if (|bp_taken_i) begin
                modelPc = bp_next_pc_i;
                bpArmed = 1'b0;
                bpFollow = 1'b1;
            end else begin
                modelPc = {modelPc[31:3] + 29'd1, 3'b000};
            end
        end

        if (br) begin
            if (respPending) stale = 1'b1;
            expQ.delete();
            modelPc = brPc & 32'hFFFF_FFFC;
            modelPriv = brPriv;
            modelNop = brPc[2];
            modelHalt = 1'b0;
            watchReq = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic found;
        rst_i = 1'b1;
        branch_request_i = 1'b0;
        branch_pc_i = '0;
        branch_priv_i = '0;
        bp_taken_i = '0;
        bp_next_pc_i = '0;
        icache_accept_i = 1'b1;
        icache_valid_i = 1'b0;
        icache_inst_i = '0;
        icache_error_i = 1'b0;
        icache_page_fault_i = 1'b0;
        fetch_accept_i = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetRd", {63'b0, icache_rd_o}, 64'd0);
        checkOutput("resetFetchValid", {63'b0, fetch_valid_o}, 64'd0);
        checkOutput("resetIcachePc", {32'b0, icache_pc_o}, 64'h8000_0000);
        checkOutput("resetPriv", {62'b0, icache_priv_o}, 64'd3);
        checkOutput("resetFetchPc", {32'b0, fetch_pc_o}, 64'd0);
        rst_i = 1'b0;

        $display("[TB] sequential fetch from BOOT_PC");
        repeat (24) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        checkOutput("firstRdCycle", 64'(firstRdCycle), 64'd2);
        checkOutput("firstValidCycle", 64'(firstValidCycle), 64'd4);
        checkOutput("throughput20", 64'(windowCount), 64'd10);

        $display("[TB] predicted taken branch");
        bpPc = {modelPc[31:3], 3'b000};
        bpArmed = 1'b1;
        repeat (10) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        checkOutput("bpNextReq", {32'b0, bpNextReq}, 64'h8000_0100);

        $display("[TB] redirect with request outstanding");
        cacheLatency = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
            if (respPending && respWait > 0) found = 1'b1;
        end
        checkOutput("outstandingSeen", {63'b0, found}, 64'd1);
        applyStimulus(1'b1, 32'h8000_0204, 2'b01, 1'b0);
        cacheLatency = 0;
        repeat (14) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        checkOutput("reqAfterRedirect", {32'b0, reqAfterBr}, 64'h8000_0200);

        $display("[TB] page fault halts fetch");
        faultArmPage = 1'b1;
        for (int i = 0; i < 10 && !modelHalt; i++) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        checkOutput("faultDelivered", {63'b0, modelHalt}, 64'd1);
        rdSeen = 0;
        repeat (10) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        checkOutput("haltNoReq", 64'(rdSeen), 64'd0);
        applyStimulus(1'b1, 32'h8000_0040, 2'b11, 1'b0);
        repeat (12) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        checkOutput("resumeReq", {32'b0, reqAfterBr}, 64'h8000_0040);

        $display("[TB] decode back-pressure");
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
            found = deliveredNow;
        end
        checkOutput("stallAligned", {63'b0, found}, 64'd1);
        rdSeen = 0;
        repeat (10) applyStimulus(1'b0, 32'h0, 2'b00, 1'b0);
        checkOutput("stallExtraReq", 64'(rdSeen), 64'(STALL_EXTRA));
        repeat (20) applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);

        cacheAccept = 1'b0;
        for (int i = 0; i < 10 && (expQ.size() != 0 || respPending); i++)
            applyStimulus(1'b0, 32'h0, 2'b00, 1'b1);
        checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
